axis_demux_4: RTL and testbench

Frame-aware AXI-Stream demultiplexer: one input stream, four output streams. It is the counterpart of the 4:1 frame arbiter/mux and shares its port naming and data/user widths. Each frame is routed whole to the output selected at its first beat, or discarded when `drop` is set at that point. Outputs are registered through a 2-entry skid buffer, so `input_tready` is a register and the block sustains one beat per cycle.

---
 rtl/axis_demux_4.sv | 239 +++++++++++++++++++++++
 tb/tb_axis_demux_4.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_4.sv
`default_nettype none
// ============================================================================
// Module   : axis_demux_4
// Purpose  : Frame-aware AXI-Stream 1:4 demultiplexer. Each frame goes whole
//            to the output chosen at its first beat, or is discarded when
//            drop is set at that beat. Outputs are fed from a 2-entry skid
//            buffer so input_tready is a flop and 1 beat/cycle is sustained.
// Ports    : clk, rst (sync, active-low)
//            enable, drop, select[1:0]     frame-start controls
//            input_t{data,valid,ready,last,user}     upstream stream
//            output_N_t{data,valid,ready,last,user}  N = 0..3 downstream
// Revision : 1.0 - initial release
// ============================================================================
module axis_demux_4 #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  enable,
    input  logic                  drop,
    input  logic [1:0]            select,

    input  logic [DATA_WIDTH-1:0] input_tdata,
    input  logic                  input_tvalid,
    output logic                  input_tready,
    input  logic                  input_tlast,
    input  logic [USER_WIDTH-1:0] input_tuser,

    output logic [DATA_WIDTH-1:0] output_0_tdata,
    output logic                  output_0_tvalid,
    input  logic                  output_0_tready,
    output logic                  output_0_tlast,
    output logic [USER_WIDTH-1:0] output_0_tuser,

    output logic [DATA_WIDTH-1:0] output_1_tdata,
    output logic                  output_1_tvalid,
    input  logic                  output_1_tready,
    output logic                  output_1_tlast,
    output logic [USER_WIDTH-1:0] output_1_tuser,

    output logic [DATA_WIDTH-1:0] output_2_tdata,
    output logic                  output_2_tvalid,
    input  logic                  output_2_tready,
    output logic                  output_2_tlast,
    output logic [USER_WIDTH-1:0] output_2_tuser,

    output logic [DATA_WIDTH-1:0] output_3_tdata,
    output logic                  output_3_tvalid,
    input  logic                  output_3_tready,
    output logic                  output_3_tlast,
    output logic [USER_WIDTH-1:0] output_3_tuser
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_DROP   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [1:0]            r_sel;
    logic                  r_in_ready;
    logic                  w_in_ready_next;

    logic                  w_accept;
    logic                  w_discard;
    logic                  w_push;
    logic [1:0]            w_push_dest;

    // Output register set
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [USER_WIDTH-1:0] r_out_user;
    logic [1:0]            r_out_dest;
    logic                  r_out_valid;

    // Temp (skid) register set
    logic [DATA_WIDTH-1:0] r_tmp_data;
    logic                  r_tmp_last;
    logic [USER_WIDTH-1:0] r_tmp_user;
    logic [1:0]            r_tmp_dest;
    logic                  r_tmp_valid;

    logic                  w_dest_ready;
    logic                  w_out_load;
    logic                  w_tmp_valid_next;

    assign input_tready = r_in_ready;
    assign w_accept     = input_tvalid & r_in_ready;
    assign w_push       = w_accept & ~w_discard;

    // Only the ready of the output currently holding a beat matters.
    always_comb begin
        w_dest_ready = 1'b0;
        case (r_out_dest)
            2'd0:    w_dest_ready = output_0_tready;
            2'd1:    w_dest_ready = output_1_tready;
            2'd2:    w_dest_ready = output_2_tready;
            default: w_dest_ready = output_3_tready;
        endcase
    end

    // Output register may take a new beat this edge (empty or being drained).
    assign w_out_load = ~r_out_valid | w_dest_ready;

    // Ready is only ever high while temp is empty, so a push never coincides
    // with a pending temp beat; temp therefore only fills when the output
    // register is held.
    assign w_tmp_valid_next = w_out_load ? 1'b0 : (r_tmp_valid | w_push);

    // Next-state / routing decode
    always_comb begin
        w_state_next = r_state;
        w_discard    = 1'b0;
        w_push_dest  = r_sel;
        case (r_state)
            c_ST_IDLE: begin
                // Frame start: controls are live; drop overrides select.
                w_push_dest = select;
                w_discard   = drop;
                if (w_accept && !input_tlast) begin
                    w_state_next = drop ? c_ST_DROP : c_ST_ACTIVE;
                end
            end
            c_ST_ACTIVE: begin
                if (w_accept && input_tlast) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_DROP: begin
                w_discard = 1'b1;
                if (w_accept && input_tlast) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Registered ready, computed from the state and skid occupancy that will
    // hold after this edge. In DROP nothing is pushed, so skid room is moot.
    always_comb begin
        w_in_ready_next = 1'b0;
        case (w_state_next)
            c_ST_IDLE:   w_in_ready_next = enable & ~w_tmp_valid_next;
            c_ST_ACTIVE: w_in_ready_next = ~w_tmp_valid_next;
            c_ST_DROP:   w_in_ready_next = 1'b1;
            default:     w_in_ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_sel      <= 2'd0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= w_in_ready_next;
            if (r_state == c_ST_IDLE && w_accept && !drop) begin
                r_sel <= select;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= '0;
            r_out_dest  <= 2'd0;
            r_out_valid <= 1'b0;
            r_tmp_data  <= '0;
            r_tmp_last  <= 1'b0;
            r_tmp_user  <= '0;
            r_tmp_dest  <= 2'd0;
            r_tmp_valid <= 1'b0;
        end else begin
            r_tmp_valid <= w_tmp_valid_next;
            if (w_out_load) begin
                if (r_tmp_valid) begin
                    // Older beat in temp goes out first to keep order.
                    r_out_data  <= r_tmp_data;
                    r_out_last  <= r_tmp_last;
                    r_out_user  <= r_tmp_user;
                    r_out_dest  <= r_tmp_dest;
                    r_out_valid <= 1'b1;
                end else if (w_push) begin
                    r_out_data  <= input_tdata;
                    r_out_last  <= input_tlast;
                    r_out_user  <= input_tuser;
                    r_out_dest  <= w_push_dest;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_tmp_data <= input_tdata;
                r_tmp_last <= input_tlast;
                r_tmp_user <= input_tuser;
                r_tmp_dest <= w_push_dest;
            end
        end
    end

    // Data/last are shared; only the destination's valid is raised.
    assign output_0_tdata  = r_out_data;
    assign output_1_tdata  = r_out_data;
    assign output_2_tdata  = r_out_data;
    assign output_3_tdata  = r_out_data;
    assign output_0_tlast  = r_out_last;
    assign output_1_tlast  = r_out_last;
    assign output_2_tlast  = r_out_last;
    assign output_3_tlast  = r_out_last;
    assign output_0_tvalid = r_out_valid & (r_out_dest == 2'd0);
    assign output_1_tvalid = r_out_valid & (r_out_dest == 2'd1);
    assign output_2_tvalid = r_out_valid & (r_out_dest == 2'd2);
    assign output_3_tvalid = r_out_valid & (r_out_dest == 2'd3);

    generate
        if (USER_ENABLE != 0) begin : g_user_on
            assign output_0_tuser = r_out_user;
            assign output_1_tuser = r_out_user;
            assign output_2_tuser = r_out_user;
            assign output_3_tuser = r_out_user;
        end else begin : g_user_off
            assign output_0_tuser = '0;
            assign output_1_tuser = '0;
            assign output_2_tuser = '0;
            assign output_3_tuser = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_demux_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_demux_4
// Purpose  : Directed, self-checking bench for axis_demux_4. Accepted beats
//            are pushed to an expectation queue; output handshakes pop and
//            compare destination, data, last and user.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_demux_4;

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
        logic       last;
        logic       user;
        int         cyc;
        bit         chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       drop;
    logic [1:0] select;
    logic [7:0] input_tdata;
    logic       input_tvalid;
    wire        input_tready;
    logic       input_tlast;
    logic       input_tuser;
    logic [3:0] rdy;
    wire  [3:0] ov;
    wire  [3:0] ol;
    wire  [3:0] ou;
    wire  [7:0] od [4];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];

    logic [3:0] m_vm;
    int         m_idx;
    exp_t       m_e;

    axis_demux_4 #(.DATA_WIDTH(8), .USER_ENABLE(1), .USER_WIDTH(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .drop(drop), .select(select),
        .input_tdata(input_tdata), .input_tvalid(input_tvalid),
        .input_tready(input_tready), .input_tlast(input_tlast),
        .input_tuser(input_tuser),
        .output_0_tdata(od[0]), .output_0_tvalid(ov[0]), .output_0_tready(rdy[0]),
        .output_0_tlast(ol[0]), .output_0_tuser(ou[0]),
        .output_1_tdata(od[1]), .output_1_tvalid(ov[1]), .output_1_tready(rdy[1]),
        .output_1_tlast(ol[1]), .output_1_tuser(ou[1]),
        .output_2_tdata(od[2]), .output_2_tvalid(ov[2]), .output_2_tready(rdy[2]),
        .output_2_tlast(ol[2]), .output_2_tuser(ou[2]),
        .output_3_tdata(od[3]), .output_3_tvalid(ov[3]), .output_3_tready(rdy[3]),
        .output_3_tlast(ol[3]), .output_3_tuser(ou[3])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: one-hot valid, front-of-queue match, pop on handshake.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            m_vm = ov;
            vectors++;
            assert ($countones(m_vm) <= 1) else begin
                miscompares++;
                $error("FAIL onehot_valid obs=%b exp=at most one set", m_vm);
            end
            if (m_vm != 4'd0) begin
                m_idx = m_vm[3] ? 3 : m_vm[2] ? 2 : m_vm[1] ? 1 : 0;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_beat obs=out%0d data=%h exp=no valid output", m_idx, od[m_idx]);
                end else begin
                    m_e = sb[0];
                    vectors++;
                    assert ({m_idx[1:0], od[m_idx], ol[m_idx], ou[m_idx]} ===
                            {m_e.dest, m_e.data, m_e.last, m_e.user}) else begin
                        miscompares++;
                        $error("FAIL route_beat obs=out%0d d=%h l=%b u=%b exp=out%0d d=%h l=%b u=%b",
                               m_idx, od[m_idx], ol[m_idx], ou[m_idx],
                               m_e.dest, m_e.data, m_e.last, m_e.user);
                    end
                    if (rdy[m_idx]) begin
                        void'(sb.pop_front());
                        if (m_e.chk) begin
                            vectors++;
                            assert (cyc == m_e.cyc + 1) else begin
                                miscompares++;
                                $error("FAIL latency data=%h obs=cycle %0d exp=cycle %0d",
                                       m_e.data, cyc, m_e.cyc + 1);
                            end
                        end
                    end
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input logic l, input logic [1:0] s,
                        input logic dr, input bit exp_out, input logic [1:0] dest,
                        input bit must_rdy, input bit chk);
        bit hs;
        int n;
        exp_t e;
        input_tdata  = d;
        input_tlast  = l;
        input_tuser  = d[0];
        select       = s;
        drop         = dr;
        input_tvalid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            if (n == 0 && must_rdy) begin
                vectors++;
                assert (input_tready === 1'b1) else begin
                    miscompares++;
                    $error("FAIL tready_high data=%h obs=%b exp=1", d, input_tready);
                end
            end
            if (input_tready === 1'b1) begin
                hs = 1'b1;
                if (exp_out) begin
                    e.dest = dest; e.data = d; e.last = l; e.user = d[0];
                    e.cyc = cyc; e.chk = chk;
                    sb.push_back(e);
                end
            end
            @(posedge clk);
            n++;
        end
        #1;
        input_tvalid = 1'b0;
        drop         = 1'b0;
        if (!hs) begin
            vectors++;
            miscompares++;
            $error("FAIL accept_timeout data=%h obs=no handshake exp=handshake", d);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL drain obs=%0d pending exp=0 pending", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        assert ({ov, input_tready, od[0], ol[0], ou[0]} === 15'd0) else begin
            miscompares++;
            $error("FAIL %s obs=valid %b rdy %b d %h l %b u %b exp=all zero",
                   tag, ov, input_tready, od[0], ol[0], ou[0]);
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; drop = 1'b0; select = 2'd0;
        input_tdata = 8'd0; input_tvalid = 1'b0; input_tlast = 1'b0;
        input_tuser = 1'b0; rdy = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        vectors++;
        assert (input_tready === 1'b0) else begin
            miscompares++;
            $error("FAIL tready_after_release obs=%b exp=0", input_tready);
        end

        // Routing to output 2 at one beat per cycle, latency 1
        send(8'h11, 1'b0, 2'd2, 1'b0, 1, 2'd2, 1, 1);
        send(8'h22, 1'b0, 2'd2, 1'b0, 1, 2'd2, 1, 1);
        send(8'h33, 1'b1, 2'd2, 1'b0, 1, 2'd2, 1, 1);
        drain();

        // Select changes mid-frame; next frame takes new select
        send(8'h31, 1'b0, 2'd1, 1'b0, 1, 2'd1, 1, 0);
        send(8'h32, 1'b0, 2'd3, 1'b0, 1, 2'd1, 1, 0);
        send(8'h33, 1'b0, 2'd3, 1'b0, 1, 2'd1, 1, 0);
        send(8'h34, 1'b1, 2'd3, 1'b0, 1, 2'd1, 1, 0);
        send(8'h41, 1'b0, 2'd3, 1'b0, 1, 2'd3, 1, 0);
        send(8'h42, 1'b1, 2'd3, 1'b0, 1, 2'd3, 1, 0);
        drain();

        // Drop frame (drop only at start), then frame to output 0
        send(8'hA0, 1'b0, 2'd2, 1'b1, 0, 2'd0, 1, 0);
        send(8'hA1, 1'b0, 2'd2, 1'b0, 0, 2'd0, 1, 0);
        send(8'hA2, 1'b0, 2'd2, 1'b0, 0, 2'd0, 1, 0);
        send(8'hA3, 1'b1, 2'd2, 1'b0, 0, 2'd0, 1, 0);
        send(8'hB0, 1'b0, 2'd0, 1'b0, 1, 2'd0, 1, 1);
        send(8'hB1, 1'b1, 2'd0, 1'b0, 1, 2'd0, 1, 1);
        drain();

        // Backpressure on output 1; other outputs not ready must not matter
        rdy = 4'b0010;
        send(8'h01, 1'b0, 2'd1, 1'b0, 1, 2'd1, 1, 0);
        rdy[1] = 1'b0;
        send(8'h02, 1'b0, 2'd1, 1'b0, 1, 2'd1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            assert ({input_tready, od[1]} === {1'b0, 8'h01}) else begin
                miscompares++;
                $error("FAIL stall_hold cyc%0d obs=rdy %b d %h exp=rdy 0 d 01", i, input_tready, od[1]);
            end
        end
        @(posedge clk); #1; rdy[1] = 1'b1;
        send(8'h03, 1'b0, 2'd1, 1'b0, 1, 2'd1, 0, 0);
        send(8'h04, 1'b0, 2'd1, 1'b0, 1, 2'd1, 0, 0);
        send(8'h05, 1'b0, 2'd1, 1'b0, 1, 2'd1, 0, 0);
        send(8'h06, 1'b1, 2'd1, 1'b0, 1, 2'd1, 0, 0);
        drain();
        rdy = 4'hF;

        // Back-to-back single-beat frames
        send(8'h5A, 1'b1, 2'd0, 1'b0, 1, 2'd0, 1, 1);
        send(8'hA5, 1'b1, 2'd3, 1'b0, 1, 2'd3, 1, 1);
        drain();

        // enable=0 in IDLE blocks acceptance
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        assert (input_tready === 1'b0) else begin
            miscompares++;
            $error("FAIL enable_low obs=%b exp=0", input_tready);
        end
        @(posedge clk); #1; enable = 1'b1;

        // Reset mid-frame with beats buffered
        send(8'h71, 1'b0, 2'd1, 1'b0, 1, 2'd1, 0, 0);
        rdy[1] = 1'b0;
        send(8'h72, 1'b0, 2'd1, 1'b0, 1, 2'd1, 1, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        rdy = 4'hF;
        @(negedge clk);
        check_idle_outputs("reset_midframe");
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        vectors++;
        assert (input_tready === 1'b0) else begin
            miscompares++;
            $error("FAIL tready_after_rerelease obs=%b exp=0", input_tready);
        end
        send(8'h81, 1'b0, 2'd2, 1'b0, 1, 2'd2, 0, 0);
        send(8'h82, 1'b1, 2'd2, 1'b0, 1, 2'd2, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
